// File: rtl/pi_math_pkg.sv
// Shared types and constants for the PI math sequencer: FSM states,
// ALU operand select encodings and the 12-bit signed saturation limits.
package pi_math_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ERR   = 3'd1,
      INTG  = 3'd2,
      ICOMP = 3'd3,
      PCOMP = 3'd4,
      ACC1  = 3'd5,
      ACC2  = 3'd6,
      DONE  = 3'd7
   } state_t;

   localparam logic [2:0] SRC1_ACCUM     = 3'd0;
   localparam logic [2:0] SRC1_ITERM     = 3'd1;
   localparam logic [2:0] SRC1_ERROR     = 3'd2;
   localparam logic [2:0] SRC1_ERR_DIV16 = 3'd3;
   localparam logic [2:0] SRC1_FWD       = 3'd4;

   localparam logic [2:0] SRC0_A2D    = 3'd0;
   localparam logic [2:0] SRC0_INTGRL = 3'd1;
   localparam logic [2:0] SRC0_ICOMP  = 3'd2;
   localparam logic [2:0] SRC0_PCOMP  = 3'd3;
   localparam logic [2:0] SRC0_PTERM  = 3'd4;

   localparam logic [15:0] SAT_POS = 16'h07FF;
   localparam logic [15:0] SAT_NEG = 16'hF800;

endpackage

// File: rtl/pi_math_seq.sv
// Control-side sequencer for the PI datapath ALU: steps the op sequence once
// per conversion and captures the ALU result into the working registers.
module pi_math_seq
   import pi_math_pkg::*;
#(
   parameter int MULT_WAIT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        strt,
   input  logic        int_en,
   input  logic [11:0] A2D_res,
   input  logic [11:0] Fwd,
   input  logic [13:0] Pterm,
   input  logic [11:0] Iterm,
   input  logic [15:0] dst,
   output logic [2:0]  src0sel,
   output logic [2:0]  src1sel,
   output logic        multiply,
   output logic        sub,
   output logic        mult2,
   output logic        mult4,
   output logic        saturate,
   output logic [15:0] Accum,
   output logic [15:0] Pcomp,
   output logic [11:0] Icomp,
   output logic [11:0] Error,
   output logic [11:0] Intgrl,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] WAIT_LAST = 2'(MULT_WAIT - 1);

   state_t     state, state_nxt;
   logic [1:0] wait_cnt;
   logic       wait_last;
   logic       int_en_q;

   // Operands reach the ALU directly from the parent; only the port list is shared.
   logic unused_operands;
   assign unused_operands = ^{A2D_res, Fwd, Pterm, Iterm};

   assign wait_last = (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      src1sel   = SRC1_ACCUM;
      src0sel   = SRC0_A2D;
      multiply  = 1'b0;
      sub       = 1'b0;
      mult2     = 1'b0;
      mult4     = 1'b0;
      saturate  = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (strt) state_nxt = ERR;
         end
         ERR: begin
            src1sel   = SRC1_FWD;
            src0sel   = SRC0_A2D;
            sub       = 1'b1;
            saturate  = 1'b1;
            state_nxt = INTG;
         end
         INTG: begin
            src1sel   = SRC1_ERR_DIV16;
            src0sel   = SRC0_INTGRL;
            saturate  = 1'b1;
            state_nxt = ICOMP;
         end
         ICOMP: begin
            src1sel  = SRC1_ITERM;
            src0sel  = SRC0_INTGRL;
            multiply = 1'b1;
            if (wait_last) state_nxt = PCOMP;
         end
         PCOMP: begin
            src1sel  = SRC1_ERROR;
            src0sel  = SRC0_PTERM;
            multiply = 1'b1;
            if (wait_last) state_nxt = ACC1;
         end
         ACC1: begin
            src1sel   = SRC1_FWD;
            src0sel   = SRC0_PCOMP;
            sub       = 1'b1;
            saturate  = 1'b1;
            state_nxt = ACC2;
         end
         ACC2: begin
            src1sel   = SRC1_ACCUM;
            src0sel   = SRC0_ICOMP;
            sub       = 1'b1;
            saturate  = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Multiply results settle over a multicycle path; capture only on the last wait cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
         int_en_q <= 1'b0;
         Error    <= '0;
         Intgrl   <= '0;
         Icomp    <= '0;
         Pcomp    <= '0;
         Accum    <= '0;
      end else begin
         wait_cnt <= (state_nxt != state) ? 2'd0 : wait_cnt + 2'd1;
         if (state == IDLE && strt) int_en_q <= int_en;
         case (state)
            ERR:   Error <= dst[11:0];
            INTG:  if (int_en_q) Intgrl <= dst[11:0];
            ICOMP: if (wait_last) Icomp <= dst[11:0];
            PCOMP: if (wait_last) Pcomp <= dst;
            ACC1,
            ACC2:  Accum <= dst;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pi_math_seq.sv
// Directed bench for pi_math_seq: a behavioural ALU closes the loop on dst,
// checking per-cycle op controls and final register values for two wait settings.
module tb_pi_math_seq;
   import pi_math_pkg::*;

   localparam int MW  = 2;
   localparam int MW3 = 3;

   logic        clk = 1'b0;
   logic        rst, strt, int_en;
   logic [11:0] A2D_res, Fwd, Iterm;
   logic [13:0] Pterm;

   logic [15:0] dst, Accum, Pcomp;
   logic [11:0] Icomp, Error, Intgrl;
   logic [2:0]  src0sel, src1sel;
   logic        multiply, sub, mult2, mult4, saturate, busy, done;

   logic [15:0] dst3, Accum3, Pcomp3;
   logic [11:0] Icomp3, Error3, Intgrl3;
   logic [2:0]  src0sel3, src1sel3;
   logic        multiply3, sub3, mult2_3, mult4_3, saturate3, busy3, done3;

   logic [12:0] ops, ops3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pi_math_seq #(.MULT_WAIT(MW)) u_dut (
      .clk(clk), .rst(rst), .strt(strt), .int_en(int_en),
      .A2D_res(A2D_res), .Fwd(Fwd), .Pterm(Pterm), .Iterm(Iterm), .dst(dst),
      .src0sel(src0sel), .src1sel(src1sel), .multiply(multiply), .sub(sub),
      .mult2(mult2), .mult4(mult4), .saturate(saturate),
      .Accum(Accum), .Pcomp(Pcomp), .Icomp(Icomp), .Error(Error), .Intgrl(Intgrl),
      .busy(busy), .done(done)
   );

   pi_math_seq #(.MULT_WAIT(MW3)) u_dut3 (
      .clk(clk), .rst(rst), .strt(strt), .int_en(int_en),
      .A2D_res(A2D_res), .Fwd(Fwd), .Pterm(Pterm), .Iterm(Iterm), .dst(dst3),
      .src0sel(src0sel3), .src1sel(src1sel3), .multiply(multiply3), .sub(sub3),
      .mult2(mult2_3), .mult4(mult4_3), .saturate(saturate3),
      .Accum(Accum3), .Pcomp(Pcomp3), .Icomp(Icomp3), .Error(Error3), .Intgrl(Intgrl3),
      .busy(busy3), .done(done3)
   );

   assign ops  = {src1sel,  src0sel,  multiply,  sub,  mult2,   mult4,   saturate,  busy,  done};
   assign ops3 = {src1sel3, src0sel3, multiply3, sub3, mult2_3, mult4_3, saturate3, busy3, done3};

   // Behavioural ALU: 12-bit signed saturation on add/sub, Q12 scaling on multiply.
   function automatic logic [15:0] alu(
      input logic [2:0]  s1sel, s0sel,
      input logic        mul, sb, sat,
      input logic [15:0] acc, pc,
      input logic [11:0] ic, er, ig,
      input logic [11:0] a2d, fwd, it,
      input logic [13:0] pt
   );
      logic [15:0]        s1, s0, sum;
      logic signed [29:0] prod;
      case (s1sel)
         3'd0:    s1 = acc;
         3'd1:    s1 = {4'h0, it};
         3'd2:    s1 = {{4{er[11]}}, er};
         3'd3:    s1 = {{8{er[11]}}, er[11:4]};
         3'd4:    s1 = {4'h0, fwd};
         default: s1 = 16'h0;
      endcase
      case (s0sel)
         3'd0:    s0 = {4'h0, a2d};
         3'd1:    s0 = {{4{ig[11]}}, ig};
         3'd2:    s0 = {{4{ic[11]}}, ic};
         3'd3:    s0 = pc;
         3'd4:    s0 = {2'b00, pt};
         default: s0 = 16'h0;
      endcase
      if (mul) begin
         prod = $signed(s1[14:0]) * $signed(s0[14:0]);
         return prod[27:12];
      end
      sum = sb ? s1 - s0 : s1 + s0;
      if (sat) begin
         if ($signed(sum) > $signed(SAT_POS))      sum = SAT_POS;
         else if ($signed(sum) < $signed(SAT_NEG)) sum = SAT_NEG;
      end
      return sum;
   endfunction

   always_comb dst  = alu(src1sel, src0sel, multiply, sub, saturate, Accum, Pcomp,
                          Icomp, Error, Intgrl, A2D_res, Fwd, Iterm, Pterm);
   always_comb dst3 = alu(src1sel3, src0sel3, multiply3, sub3, saturate3, Accum3, Pcomp3,
                          Icomp3, Error3, Intgrl3, A2D_res, Fwd, Iterm, Pterm);

   // {src1sel, src0sel, multiply, sub, mult2, mult4, saturate, busy, done}
   // j counts cycles after the edge that sampled strt.
   function automatic logic [12:0] exp_ops(input int j, input int mw);
      if (j == 0)                return 13'b100_000_0_1_0_0_1_1_0;
      if (j == 1)                return 13'b011_001_0_0_0_0_1_1_0;
      if (j < 2 + mw)            return 13'b001_001_1_0_0_0_0_1_0;
      if (j < 2 + 2*mw)          return 13'b010_100_1_0_0_0_0_1_0;
      if (j == 2 + 2*mw)         return 13'b100_011_0_1_0_0_1_1_0;
      if (j == 3 + 2*mw)         return 13'b000_010_0_1_0_0_1_1_0;
      if (j == 4 + 2*mw)         return 13'b000_000_0_0_0_0_0_1_1;
      return 13'h0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_regs(input logic [11:0] er, ig, ic, input logic [15:0] pc, ac);
      chk("error",   Error,   er);
      chk("intgrl",  Intgrl,  ig);
      chk("icomp",   Icomp,   ic);
      chk("pcomp",   Pcomp,   pc);
      chk("accum",   Accum,   ac);
      chk("error3",  Error3,  er);
      chk("intgrl3", Intgrl3, ig);
      chk("icomp3",  Icomp3,  ic);
      chk("pcomp3",  Pcomp3,  pc);
      chk("accum3",  Accum3,  ac);
   endtask

   // One full run; rep re-pulses strt (with int_en flipped) in PCOMP and in DONE.
   task automatic run_seq(input logic ie, input logic rep);
      @(negedge clk);
      strt = 1'b1; int_en = ie;
      for (int j = 0; j <= 5 + 2*MW3; j++) begin
         @(negedge clk);
         strt = 1'b0; int_en = ie;
         chk($sformatf("ops_j%0d", j),  ops,  exp_ops(j, MW));
         chk($sformatf("ops3_j%0d", j), ops3, exp_ops(j, MW3));
         if (rep && (j == 2 + MW || j == 4 + 2*MW)) begin
            strt = 1'b1; int_en = ~ie;
         end
      end
   endtask

   initial begin
      rst = 1'b1; strt = 1'b0; int_en = 1'b0;
      Fwd = 12'h400; A2D_res = 12'h3C0; Pterm = 14'h3680; Iterm = 12'h500;
      #12;
      chk("rst_regs",  {Accum, Pcomp, Icomp, Error, Intgrl}, 64'h0);
      chk("rst_ops",   ops, 13'h0);
      chk("rst_regs3", {Accum3, Pcomp3, Icomp3, Error3, Intgrl3}, 64'h0);
      @(negedge clk) rst = 1'b0;

      // nominal
      run_seq(1'b1, 1'b0);
      check_regs(12'h040, 12'h004, 12'h001, 16'h00DA, 16'h0325);

      // integrator frozen
      run_seq(1'b0, 1'b0);
      check_regs(12'h040, 12'h004, 12'h001, 16'h00DA, 16'h0325);

      // strt re-pulsed mid-run and on DONE
      run_seq(1'b1, 1'b1);
      check_regs(12'h040, 12'h008, 12'h002, 16'h00DA, 16'h0324);

      // async reset mid-ICOMP
      @(negedge clk);
      strt = 1'b1; int_en = 1'b1;
      @(negedge clk) strt = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_abort_ops", ops, exp_ops(2, MW));
      #2 rst = 1'b1;
      #1;
      chk("abort_regs",  {Accum, Pcomp, Icomp, Error, Intgrl}, 64'h0);
      chk("abort_ops",   ops, 13'h0);
      chk("abort_regs3", {Accum3, Pcomp3, Icomp3, Error3, Intgrl3}, 64'h0);
      chk("abort_ops3",  ops3, 13'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_done", {done, done3}, 2'b00);
      end
      rst = 1'b0;
      run_seq(1'b1, 1'b0);
      check_regs(12'h040, 12'h004, 12'h001, 16'h00DA, 16'h0325);

      // saturation from cleared registers: integrator walks down -128 per run
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      Fwd = 12'h000; A2D_res = 12'hFFF;
      for (int n = 1; n <= 17; n++) begin
         logic [11:0] ig_exp;
         ig_exp = (n >= 16) ? 12'h800 : 12'(-128 * n);
         run_seq(1'b1, 1'b0);
         chk($sformatf("sat_error_%0d", n),  Error,   12'h800);
         chk($sformatf("sat_intgrl_%0d", n), Intgrl,  ig_exp);
         chk($sformatf("sat_accum_%0d", n),  Accum,   16'h07FF);
         chk($sformatf("sat_intgrl3_%0d", n), Intgrl3, ig_exp);
         if (n == 1) begin
            chk("sat_icomp", Icomp, 12'hFD8);
            chk("sat_pcomp", Pcomp, 16'hE4C0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pi_math_seq.md
Name: pi_math_seq

Overview:
- Sequencer and register file on the control side of the PI datapath ALU.
- On each completed A2D conversion it issues a fixed sequence of ALU operations: drives src0sel/src1sel/multiply/sub/mult2/mult4/saturate and captures the ALU dst result into the working registers.
- Computes Error, Intgrl, Icomp, Pcomp and Accum. The final Accum is the motor drive command.

Parameters:
- MULT_WAIT, 2, cycles each multiply step holds its selects before capture (multicycle path through the 15x15 multiplier); legal range 1..4.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- strt  input  1  one-cycle pulse, new A2D_res valid
- int_en  input  1  integrator update enable, sampled with strt
- A2D_res  input  12  unsigned conversion result, stable from strt to done
- Fwd  input  12  unsigned forward-speed setpoint
- Pterm  input  14  unsigned proportional gain
- Iterm  input  12  integral gain
- dst  input  16  ALU result
- src0sel  output  3  ALU src0 select
- src1sel  output  3  ALU src1 select
- multiply, sub, mult2, mult4, saturate  output  1 each  ALU op controls
- Accum  output  16  accumulator register, fed back to ALU
- Pcomp  output  16  proportional component register
- Icomp  output  12  integral component register
- Error  output  12  error register
- Intgrl  output  12  integrator register
- busy  output  1  high from first state after strt through DONE inclusive
- done  output  1  one-cycle pulse, Accum holds the final result

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - All registers clear to 0; busy, done and all op controls clear to 0.
  - src0sel and src1sel reset to 3'b000.
- Encodings: src1 0=Accum, 1=Iterm, 2=Error, 3=Error>>>4, 4=Fwd. src0 0=A2D_res, 1=Intgrl, 2=Icomp, 3=Pcomp, 4=Pterm.
- State sequence (one state per cycle unless noted). Ops are Moore-decoded from state. Captures happen on the clock edge that ends the state.
  - IDLE: op controls 0, sels 0. On strt go to ERR and latch int_en into int_en_q.
  - ERR: src1=4, src0=0, sub, saturate. Error <= dst[11:0].
  - INTG: src1=3, src0=1, saturate. Intgrl <= dst[11:0] only if int_en_q; otherwise Intgrl holds.
  - ICOMP: MULT_WAIT cycles. src1=1, src0=1, multiply. Icomp <= dst[11:0] at the last cycle only.
  - PCOMP: MULT_WAIT cycles. src1=2, src0=4, multiply. Pcomp <= dst at the last cycle only.
  - ACC1: src1=4, src0=3, sub, saturate. Accum <= dst.
  - ACC2: src1=0, src0=2, sub, saturate. Accum <= dst.
  - DONE: done=1 for one cycle, then IDLE.
- mult2 and mult4 are always 0 in this sequence; the ports exist for the ALU interface.
- A 2-bit wait counter times the multiply states. It reloads on state entry.
- Latency with MULT_WAIT=2: strt sampled at edge k gives done high in the cycle after edge k+8. In general, done follows after 5+2*MULT_WAIT edges.
- strt while busy is ignored (no queueing) and does not re-latch int_en.
- strt coincident with DONE is ignored.
- Registers hold between runs. Intgrl persists across runs as the integrator state.
- Reset mid-sequence aborts the run immediately. No done is issued, and registers clear.

Decomposition:
- Package pi_math_pkg:
  - state enum (IDLE, ERR, INTG, ICOMP, PCOMP, ACC1, ACC2, DONE)
  - localparams for the src0/src1 select encodings (SRC1_ACCUM... SRC0_PTERM)
  - saturation constants 16'h07FF/16'hF800
- No sub-module. The FSM, wait counter and capture registers stay in one module.
- The ALU is instantiated alongside this block by the parent, not inside it.

Test Plan:
- Nominal run: Fwd=0x400, A2D_res=0x3C0, Pterm=0x3680, Iterm=0x500, int_en=1, regs from reset, strt pulse.
  - Expected: Error=0x040, Intgrl=0x004, Icomp=0x001, Pcomp=0x00DA, Accum=0x0325, done exactly 9 cycles after strt edge.
- Saturation: Fwd=0, A2D_res=0xFFF.
  - Error=0x800 (from 0xF800).
  - Repeat 16 runs with int_en=1: Intgrl steps -128 per run and sticks at 0x800 thereafter.
- int_en=0 run: same stimulus as nominal after one nominal run.
  - Intgrl stays 0x004; Error, Icomp, Pcomp, Accum recompute.
- Op-control check per state: bench asserts the exact sel/multiply/sub/saturate vector each cycle against the state table.
  - MULT_WAIT=3 build: capture only on the third multiply cycle, done at edge k+10.
- strt re-pulsed during PCOMP and on the DONE cycle.
  - No restart; a single done; int_en change at those pulses has no effect.
- Async rst asserted mid-ICOMP.
  - All outputs 0 immediately without a clock.
  - No done; next strt after release runs a full sequence from IDLE.
